// File: rtl/strassen_block_accumulator_if.sv
// Handshake bundle between the Strassen core, the block accumulator and writeback.
// Carries the four core product lanes inbound and the serialized accumulated words outbound.
interface strassen_block_accumulator_if #(
    parameter int WIDTH     = 16,
    parameter int ACC_GUARD = 4
);
    localparam int ACC_W = 2*WIDTH + ACC_GUARD;

    logic                   in_valid;
    logic                   in_ready;
    logic                   in_last;
    logic [2*WIDTH-1:0]     in_c11;
    logic [2*WIDTH-1:0]     in_c12;
    logic [2*WIDTH-1:0]     in_c21;
    logic [2*WIDTH-1:0]     in_c22;
    logic                   out_valid;
    logic                   out_ready;
    logic [ACC_W-1:0]       out_data;
    logic [1:0]             out_idx;
    logic                   out_last;
    logic                   out_ovf;
    logic [ACC_GUARD:0]     blk_cnt;

    modport slave (
        input  in_valid, in_last, in_c11, in_c12, in_c21, in_c22, out_ready,
        output in_ready, out_valid, out_data, out_idx, out_last, out_ovf, blk_cnt
    );

    modport master (
        output in_valid, in_last, in_c11, in_c12, in_c21, in_c22, out_ready,
        input  in_ready, out_valid, out_data, out_idx, out_last, out_ovf, blk_cnt
    );
endinterface

// File: rtl/strassen_block_accumulator.sv
// Sums 2x2 Strassen partial products per output block, then streams the four words out.
// Latency: first word one cycle after the in_last beat, then one word per accepted cycle.
// Backpressure: input held off (in_ready=0) for the whole drain; output words hold while out_ready is low.
module strassen_block_accumulator #(
    parameter int WIDTH     = 16,
    parameter int ACC_GUARD = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    strassen_block_accumulator_if.slave bus
);
    localparam int ACC_W = 2*WIDTH + ACC_GUARD;
    localparam int CNT_W = ACC_GUARD + 1;
    localparam logic [CNT_W-1:0] CNT_EXACT = CNT_W'(2**ACC_GUARD);

    typedef enum logic {ACCUM, DRAIN} state_t;

    state_t           state, state_nxt;
    logic [ACC_W-1:0] acc      [4];
    logic [ACC_W-1:0] lane_ext [4];
    logic [CNT_W-1:0] cnt;
    logic             ovf_r;
    logic [1:0]       idx;
    logic             in_rdy, out_vld;
    logic             accept, out_fire, drain_done;

    always_comb begin
        lane_ext[0] = {{ACC_GUARD{bus.in_c11[2*WIDTH-1]}}, bus.in_c11};
        lane_ext[1] = {{ACC_GUARD{bus.in_c12[2*WIDTH-1]}}, bus.in_c12};
        lane_ext[2] = {{ACC_GUARD{bus.in_c21[2*WIDTH-1]}}, bus.in_c21};
        lane_ext[3] = {{ACC_GUARD{bus.in_c22[2*WIDTH-1]}}, bus.in_c22};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ACCUM;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_rdy    = 1'b0;
        out_vld   = 1'b0;
        case (state)
            ACCUM: begin
                in_rdy = 1'b1;
                if (bus.in_valid && bus.in_last) state_nxt = DRAIN;
            end
            DRAIN: begin
                out_vld = 1'b1;
                if (bus.out_ready && idx == 2'd3) state_nxt = ACCUM;
            end
        endcase
    end

    assign accept     = bus.in_valid && in_rdy;
    assign out_fire   = out_vld && bus.out_ready;
    assign drain_done = out_fire && (idx == 2'd3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) acc[i] <= '0;
            cnt   <= '0;
            ovf_r <= 1'b0;
            idx   <= 2'd0;
        end else begin
            if (accept) begin
                for (int i = 0; i < 4; i++) acc[i] <= acc[i] + lane_ext[i];
                if (cnt != '1)         cnt   <= cnt + 1'b1;
                // This accept is product number cnt+1; past 2^ACC_GUARD the guard bits no longer suffice.
                if (cnt >= CNT_EXACT)  ovf_r <= 1'b1;
            end
            if (drain_done) begin
                for (int i = 0; i < 4; i++) acc[i] <= '0;
                cnt   <= '0;
                ovf_r <= 1'b0;
                idx   <= 2'd0;
            end else if (out_fire) begin
                idx <= idx + 2'd1;
            end
        end
    end

    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = out_vld;
    assign bus.out_data  = out_vld ? acc[idx] : '0;
    assign bus.out_idx   = idx;
    assign bus.out_last  = out_vld && (idx == 2'd3);
    assign bus.out_ovf   = out_vld && ovf_r;
    assign bus.blk_cnt   = cnt;
endmodule

// File: tb/tb_strassen_block_accumulator.sv
// Directed bench for strassen_block_accumulator: drives and samples on the falling edge.
module tb_strassen_block_accumulator;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    strassen_block_accumulator_if #(.WIDTH(16), .ACC_GUARD(4)) bus ();

    strassen_block_accumulator #(.WIDTH(16), .ACC_GUARD(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [31:0] c11, input logic [31:0] c12,
                        input logic [31:0] c21, input logic [31:0] c22,
                        input logic last, input string tag);
        bus.in_valid = 1'b1;
        bus.in_last  = last;
        bus.in_c11   = c11;
        bus.in_c12   = c12;
        bus.in_c21   = c21;
        bus.in_c22   = c22;
        #1;
        check({tag, ".in_ready"}, 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic quiet_send(input logic [31:0] v, input logic last);
        bus.in_valid = 1'b1;
        bus.in_last  = last;
        bus.in_c11   = v;
        bus.in_c12   = v;
        bus.in_c21   = v;
        bus.in_c22   = v;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic expect_word(input string tag, input logic [35:0] d, input logic [1:0] idx,
                               input logic ovf, input logic [4:0] cnt);
        check({tag, ".valid"},    64'(bus.out_valid), 64'd1);
        check({tag, ".data"},     64'(bus.out_data),  64'(d));
        check({tag, ".idx"},      64'(bus.out_idx),   64'(idx));
        check({tag, ".last"},     64'(bus.out_last),  64'(idx == 2'd3));
        check({tag, ".ovf"},      64'(bus.out_ovf),   64'(ovf));
        check({tag, ".in_ready"}, 64'(bus.in_ready),  64'd0);
        check({tag, ".blk_cnt"},  64'(bus.blk_cnt),   64'(cnt));
    endtask

    task automatic drain4(input string tag, input logic [35:0] e0, input logic [35:0] e1,
                          input logic [35:0] e2, input logic [35:0] e3,
                          input logic ovf, input logic [4:0] cnt);
        logic [35:0] exp [4];
        exp[0] = e0; exp[1] = e1; exp[2] = e2; exp[3] = e3;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            expect_word($sformatf("%s.w%0d", tag, i), exp[i], 2'(i), ovf, cnt);
            @(posedge clk);
            @(negedge clk);
        end
        bus.out_ready = 1'b0;
        check({tag, ".back_in_ready"}, 64'(bus.in_ready),  64'd1);
        check({tag, ".back_out_valid"}, 64'(bus.out_valid), 64'd0);
        check({tag, ".back_blk_cnt"},  64'(bus.blk_cnt),   64'd0);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.in_c11    = '0;
        bus.in_c12    = '0;
        bus.in_c21    = '0;
        bus.in_c22    = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst.in_ready",  64'(bus.in_ready),  64'd1);
        check("rst.out_valid", 64'(bus.out_valid), 64'd0);
        check("rst.out_data",  64'(bus.out_data),  64'd0);
        check("rst.out_idx",   64'(bus.out_idx),   64'd0);
        check("rst.out_last",  64'(bus.out_last),  64'd0);
        check("rst.out_ovf",   64'(bus.out_ovf),   64'd0);
        check("rst.blk_cnt",   64'(bus.blk_cnt),   64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // single-beat block
        send(32'd19, 32'd22, 32'd43, 32'd50, 1'b1, "single");
        drain4("single", 36'd19, 36'd22, 36'd43, 36'd50, 1'b0, 5'd1);

        // two-beat accumulation
        send(32'd1, 32'd2, 32'd3, 32'd4, 1'b0, "two.b0");
        check("two.cnt_mid",   64'(bus.blk_cnt),   64'd1);
        check("two.no_output", 64'(bus.out_valid), 64'd0);
        send(32'd10, 32'd20, 32'd30, 32'd40, 1'b1, "two.b1");
        drain4("two", 36'd11, 36'd22, 36'd33, 36'd44, 1'b0, 5'd2);

        // sign extension
        send(32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 1'b0, "sign.b0");
        send(32'd2, 32'd0, 32'd0, 32'd0, 1'b1, "sign.b1");
        drain4("sign", 36'h0_0000_0001, 36'd0, 36'd0, 36'd0, 1'b0, 5'd2);
        send(32'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 1'b1, "neg");
        drain4("neg", 36'd0, 36'hF_8000_0000, 36'hF_FFFF_FFFF, 36'h0_7FFF_FFFF, 1'b0, 5'd1);

        // backpressure at idx 1 with in_valid pushing throughout
        send(32'd100, 32'd200, 32'd300, 32'd400, 1'b1, "bp");
        bus.out_ready = 1'b1;
        expect_word("bp.w0", 36'd100, 2'd0, 1'b0, 5'd1);
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_last   = 1'b1;
        bus.in_c11    = 32'd7;
        bus.in_c12    = 32'd7;
        bus.in_c21    = 32'd7;
        bus.in_c22    = 32'd7;
        for (int i = 0; i < 3; i++) begin
            expect_word($sformatf("bp.stall%0d", i), 36'd200, 2'd1, 1'b0, 5'd1);
            @(posedge clk);
            @(negedge clk);
        end
        expect_word("bp.w1_pre", 36'd200, 2'd1, 1'b0, 5'd1);
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        expect_word("bp.w2", 36'd300, 2'd2, 1'b0, 5'd1);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        expect_word("bp.w3", 36'd400, 2'd3, 1'b0, 5'd1);
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("bp.back_in_ready", 64'(bus.in_ready), 64'd1);
        check("bp.back_blk_cnt",  64'(bus.blk_cnt),  64'd0);

        // exactly 2^ACC_GUARD products: no overflow
        for (int i = 0; i < 16; i++) quiet_send(32'd1, i == 15);
        drain4("ovf16", 36'd16, 36'd16, 36'd16, 36'd16, 1'b0, 5'd16);
        // one more product: overflow flagged
        for (int i = 0; i < 17; i++) quiet_send(32'd1, i == 16);
        drain4("ovf17", 36'd17, 36'd17, 36'd17, 36'd17, 1'b1, 5'd17);
        send(32'd2, 32'd2, 32'd2, 32'd2, 1'b1, "after_ovf");
        drain4("after_ovf", 36'd2, 36'd2, 36'd2, 36'd2, 1'b0, 5'd1);

        // asynchronous reset in the middle of a drain
        send(32'd9, 32'd9, 32'd9, 32'd9, 1'b1, "abort");
        bus.out_ready = 1'b1;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("abort.idx_before", 64'(bus.out_idx), 64'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort.out_valid", 64'(bus.out_valid), 64'd0);
        check("abort.in_ready",  64'(bus.in_ready),  64'd1);
        check("abort.out_idx",   64'(bus.out_idx),   64'd0);
        check("abort.blk_cnt",   64'(bus.blk_cnt),   64'd0);
        bus.out_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(32'd5, 32'd6, 32'd7, 32'd8, 1'b1, "post_rst");
        drain4("post_rst", 36'd5, 36'd6, 36'd7, 36'd8, 1'b0, 5'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1);
    end
endmodule
